// File: rtl/mux21_arbiter.sv
// mux21_arbiter: round-robin owner of a MUX21's S/ENb with break-before-make dead time
// and a maximum hold limit so neither requester can starve the other.
module mux21_arbiter #(
    parameter int MAX_HOLD    = 8,
    parameter int DEAD_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic CLK,
    input  logic RSTb,
    input  logic REQ0,
    input  logic REQ1,
    output logic GNT0,
    output logic GNT1,
    output logic S,
    output logic ENb,
    output logic BUSY,
    output logic PREEMPT
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DEAD} state_t;
    state_t state, state_nxt, arb;
    logic [CNT_W-1:0] hold_cnt, hold_nxt, dead_cnt, dead_nxt;
    logic last, last_nxt, s_nxt, preempt_nxt;
    logic req_own, req_oth, at_max, release_norm, release_pre, entering;
    // The requester that was not served last wins; the last owner only gets a re-grant when alone.
    assign arb = (last ? REQ0 : REQ1) ? (last ? GRANT0 : GRANT1) :
                 (last ? REQ1 : REQ0) ? (last ? GRANT1 : GRANT0) : IDLE;
    assign req_own      = (state == GRANT1) ? REQ1 : REQ0;
    assign req_oth      = (state == GRANT1) ? REQ0 : REQ1;
    assign at_max       = (MAX_HOLD > 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    assign release_norm = !req_own;
    assign release_pre  = at_max && req_oth && req_own;
    assign entering     = (state_nxt == GRANT0 || state_nxt == GRANT1) && state_nxt != state;
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        dead_nxt    = dead_cnt;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: state_nxt = arb;
            GRANT0, GRANT1: begin
                if (release_norm || release_pre) begin
                    preempt_nxt = release_pre;
                    state_nxt   = (DEAD_CYCLES == 0) ? arb : DEAD;
                    dead_nxt    = CNT_W'(1);
                end else if (hold_cnt < CNT_W'(MAX_HOLD)) begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (dead_cnt == CNT_W'(DEAD_CYCLES)) state_nxt = arb;
                else dead_nxt = dead_cnt + CNT_W'(1);
            end
        endcase
        hold_nxt = entering ? CNT_W'(1) : hold_nxt;
        last_nxt = entering ? (state_nxt == GRANT1) : last;
        s_nxt    = entering ? (state_nxt == GRANT1) : S;
    end
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= IDLE;
            hold_cnt <= '0;
            dead_cnt <= '0;
            last     <= 1'b1;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            S        <= 1'b0;
            ENb      <= 1'b1;
            BUSY     <= 1'b0;
            PREEMPT  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            dead_cnt <= dead_nxt;
            last     <= last_nxt;
            GNT0     <= state_nxt == GRANT0;
            GNT1     <= state_nxt == GRANT1;
            S        <= s_nxt;
            ENb      <= !(state_nxt == GRANT0 || state_nxt == GRANT1);
            BUSY     <= state_nxt != IDLE;
            PREEMPT  <= preempt_nxt;
        end
    end
endmodule

// File: tb/tb_mux21_arbiter.sv
// tb_mux21_arbiter: directed vectors against hand-computed output words
// {GNT0,GNT1,S,ENb,BUSY,PREEMPT}; a second instance covers the zero dead-time handover.
module tb_mux21_arbiter;
    logic CLK, RSTb, REQ0, REQ1, r0b, r1b;
    logic GNT0, GNT1, S, ENb, BUSY, PREEMPT;
    logic g0b, g1b, sb, enbb, busyb, preb;
    logic [5:0] outs, outs2;
    int total = 0;
    int passed = 0;

    mux21_arbiter #(.MAX_HOLD(8), .DEAD_CYCLES(1), .CNT_W(4)) dut (
        .CLK(CLK), .RSTb(RSTb), .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0), .GNT1(GNT1),
        .S(S), .ENb(ENb), .BUSY(BUSY), .PREEMPT(PREEMPT)
    );
    mux21_arbiter #(.MAX_HOLD(8), .DEAD_CYCLES(0), .CNT_W(4)) dut_nodead (
        .CLK(CLK), .RSTb(RSTb), .REQ0(r0b), .REQ1(r1b), .GNT0(g0b), .GNT1(g1b),
        .S(sb), .ENb(enbb), .BUSY(busyb), .PREEMPT(preb)
    );

    assign outs  = {GNT0, GNT1, S, ENb, BUSY, PREEMPT};
    assign outs2 = {g0b, g1b, sb, enbb, busyb, preb};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        else passed++;
    endtask

    task automatic do_reset();
        RSTb = 1'b0;
        @(negedge CLK);
        RSTb = 1'b1;
    endtask

    initial begin
        RSTb = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; r0b = 1'b0; r1b = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset", outs, 6'b000100);
        check("reset_nodead", outs2, 6'b000100);
        RSTb = 1'b1;
        REQ0 = 1'b1;
        @(negedge CLK);
        check("grant0", outs, 6'b100010);
        for (int i = 0; i < 49; i++) begin
            @(negedge CLK);
            check("hold0_alone", outs, 6'b100010);
        end
        REQ0 = 1'b0;
        @(negedge CLK);
        check("dead_after_release", outs, 6'b000110);
        @(negedge CLK);
        check("idle", outs, 6'b000100);

        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 8; k++) begin
                @(negedge CLK);
                check(r == 0 ? "rr_gnt0" : "rr_gnt1", outs, r == 0 ? 6'b100010 : 6'b011010);
            end
            @(negedge CLK);
            check(r == 0 ? "preempt0" : "preempt1", outs, r == 0 ? 6'b000111 : 6'b001111);
        end
        @(negedge CLK);
        check("rr_back_to0", outs, 6'b100010);

        REQ0 = 1'b0; REQ1 = 1'b0;
        do_reset();
        REQ1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            check("gnt1_to_max", outs, 6'b011010);
            REQ0 = (k >= 4);
            if (k == 8) REQ1 = 1'b0;
        end
        @(negedge CLK);
        check("drop_at_max_no_preempt", outs, 6'b001110);
        @(negedge CLK);
        check("gnt0_after_dead", outs, 6'b100010);

        #3 RSTb = 1'b0;
        #1 check("async_reset", outs, 6'b000100);
        @(negedge CLK);
        REQ0 = 1'b1; REQ1 = 1'b1;
        RSTb = 1'b1;
        @(negedge CLK);
        check("first_tie_after_reset", outs, 6'b100010);

        REQ0 = 1'b0; REQ1 = 1'b0;
        do_reset();
        r1b = 1'b1;
        @(negedge CLK);
        check("nodead_gnt1", outs2, 6'b011010);
        r1b = 1'b0; r0b = 1'b1;
        @(negedge CLK);
        check("nodead_direct_handover", outs2, 6'b100010);
        r0b = 1'b0;
        @(negedge CLK);
        check("nodead_idle", outs2, 6'b000100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
